// File: rtl/riscv_fwd_hazard_unit_if.sv
// Operand-forwarding / load-use hazard bundle between the ID/EX register, the
// hazard unit and the EX-stage ALU operand muxes.
interface riscv_fwd_hazard_unit_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  id_we;
  logic                  id_is_load;
  logic                  id_asel_pc;
  logic                  id_bsel_imm;
  logic                  flush;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_imm;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       mem_alu_data;
  logic [XLEN-1:0]       wb_data;
  logic                  stall;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [XLEN-1:0]       op_a;
  logic [XLEN-1:0]       op_b;
  logic [XLEN-1:0]       fwd_rs2_data;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_we,
           id_is_load, id_asel_pc, id_bsel_imm, flush,
           ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, mem_alu_data, wb_data,
    input  stall, fwd_a_sel, fwd_b_sel, op_a, op_b, fwd_rs2_data
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_we,
           id_is_load, id_asel_pc, id_bsel_imm, flush,
           ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, mem_alu_data, wb_data,
    output stall, fwd_a_sel, fwd_b_sel, op_a, op_b, fwd_rs2_data
  );
endinterface

// File: rtl/riscv_fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use stall generation for a 5-stage
// RISC-V pipeline, tracking its own EX/MEM/WB destination scoreboard.
module riscv_fwd_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  riscv_fwd_hazard_unit_if.slave       bus
);
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use1;
    logic                  use2;
    logic                  asel;
    logic                  bsel;
  } entry_t;

  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  entry_t     ex_reg, mem_reg, wb_reg;
  entry_t     id_entry;
  logic [1:0] cnt_reg, cnt_next;
  logic       haz;
  logic       stall;

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rd      = bus.id_rd;
    id_entry.we      = bus.id_we;
    id_entry.is_load = bus.id_is_load;
    id_entry.rs1     = bus.id_rs1;
    id_entry.rs2     = bus.id_rs2;
    id_entry.use1    = bus.id_use_rs1;
    id_entry.use2    = bus.id_use_rs2;
    id_entry.asel    = bus.id_asel_pc;
    id_entry.bsel    = bus.id_bsel_imm;
  end

  assign haz = bus.id_valid & ex_reg.valid & ex_reg.is_load & ex_reg.we
             & (ex_reg.rd != '0)
             & ((bus.id_use_rs1 & (bus.id_rs1 == ex_reg.rd))
              | (bus.id_use_rs2 & (bus.id_rs2 == ex_reg.rd)));

  // A taken branch kills the dependant, so it must never be stalled for.
  assign stall     = ((cnt_reg != 2'd0) | haz) & ~bus.flush;
  assign bus.stall = stall;

  always_comb begin
    cnt_next = cnt_reg;
    if (bus.flush) begin
      cnt_next = 2'd0;
    end else if (cnt_reg != 2'd0) begin
      cnt_next = cnt_reg - 2'd1;
    end else if (haz) begin
      cnt_next = LAT_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg  <= '0;
      mem_reg <= '0;
      wb_reg  <= '0;
      cnt_reg <= 2'd0;
    end else begin
      wb_reg  <= mem_reg;
      mem_reg <= ex_reg;
      ex_reg  <= (bus.id_valid & ~stall & ~bus.flush) ? id_entry : '0;
      cnt_reg <= cnt_next;
    end
  end

  logic [REG_ADDR_W-1:0] src_idx [2];
  logic                  src_use [2];
  logic [XLEN-1:0]       src_rf  [2];
  logic [1:0]            fwd_sel [2];
  logic [XLEN-1:0]       fwd_val [2];

  assign src_idx[0] = ex_reg.rs1;
  assign src_idx[1] = ex_reg.rs2;
  assign src_use[0] = ex_reg.use1;
  assign src_use[1] = ex_reg.use2;
  assign src_rf[0]  = bus.ex_rs1_data;
  assign src_rf[1]  = bus.ex_rs2_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic mem_hit, wb_hit;
    // Load data is not available in MEM; the stall pushes the dependant back to WB.
    assign mem_hit = src_use[gi] & (src_idx[gi] != '0) & mem_reg.valid & mem_reg.we
                   & ~mem_reg.is_load & (mem_reg.rd == src_idx[gi]);
    assign wb_hit  = src_use[gi] & (src_idx[gi] != '0) & wb_reg.valid & wb_reg.we
                   & (wb_reg.rd == src_idx[gi]);
    assign fwd_sel[gi] = mem_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);
    assign fwd_val[gi] = mem_hit ? bus.mem_alu_data : (wb_hit ? bus.wb_data : src_rf[gi]);
  end

  assign bus.fwd_a_sel    = ex_reg.asel ? 2'b11 : fwd_sel[0];
  assign bus.fwd_b_sel    = ex_reg.bsel ? 2'b11 : fwd_sel[1];
  assign bus.op_a         = ex_reg.asel ? bus.ex_pc : fwd_val[0];
  assign bus.op_b         = ex_reg.bsel ? bus.ex_imm : fwd_val[1];
  assign bus.fwd_rs2_data = fwd_val[1];

  logic unused_fields;
  assign unused_fields = ^{mem_reg.rs1, mem_reg.rs2, mem_reg.use1, mem_reg.use2,
                           mem_reg.asel, mem_reg.bsel, wb_reg.is_load, wb_reg.rs1,
                           wb_reg.rs2, wb_reg.use1, wb_reg.use2, wb_reg.asel,
                           wb_reg.bsel};
endmodule
